apb_cmd_arbiter: RTL and testbench

APB_CMD_ARBITER -- requirements
Module: apb_cmd_arbiter

---
 rtl/apb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 31 +++
 rtl/apb_cmd_arbiter.sv | 113 +++++++++++
 tb/tb_apb_cmd_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB command arbiter slice.
package apb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int calc_iw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Command width: {pwrite, pstrb, pwdata, paddr}.
    function automatic int calc_cw(input int dw, input int aw);
        return 1 + (dw / 8) + dw + aw;
    endfunction

    // Response width: {pslverr, prdata}.
    function automatic int calc_rw(input int dw);
        return 1 + dw;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping to the lowest requesters afterwards.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Two passes instead of a modulo index: upper segment first, then wrap.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_valid && i_req[j] && (IW'(j) >= i_ptr)) begin
                o_valid = 1'b1;
                o_idx   = IW'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_valid && i_req[j] && (IW'(j) < i_ptr)) begin
                o_valid = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter feeding NREQ command requesters into one APB master.
// One arbitration cycle (IDLE) precedes every granted command (GRANT).
module apb_cmd_arbiter
    import apb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 32,
    parameter  int AW   = 8,
    localparam int SW   = DW / 8,
    localparam int CW   = 1 + SW + DW + AW,
    localparam int RW   = calc_rw(DW),
    localparam int IW   = calc_iw(NREQ)
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NREQ*CW-1:0]   i_cmd,
    input  logic [NREQ-1:0]      i_valid,
    output logic [NREQ-1:0]      o_ready,
    output logic [RW-1:0]        o_resp,
    output logic [CW-1:0]        o_cmd,
    output logic                 o_valid,
    input  logic [RW-1:0]        i_resp,
    input  logic                 i_ready,
    output logic [NREQ-1:0]      o_gnt,
    output logic                 o_busy
);

    state_t            r_state;
    logic [IW-1:0]     r_gnt_ff;
    logic [IW-1:0]     r_rr_ptr;

    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_idx;
    logic [CW-1:0]     w_cmd_sel;
    logic              w_vld_sel;
    logic [NREQ-1:0]   w_onehot;
    logic [IW-1:0]     w_ptr_next;

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_picker (
        .i_req   (i_valid),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Decode the held grant index into command slice, valid bit and one-hot.
    always_comb begin
        w_cmd_sel = '0;
        w_vld_sel = 1'b0;
        w_onehot  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IW'(k) == r_gnt_ff) begin
                w_cmd_sel   = i_cmd[k*CW +: CW];
                w_vld_sel   = i_valid[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Pointer moves one past the requester just served, wrapping at NREQ.
    always_comb begin
        w_ptr_next = (r_gnt_ff == IW'(NREQ - 1)) ? '0 : r_gnt_ff + 1'b1;
    end

    // Arbitration state machine; grant held until handshake or valid drop.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= IDLE;
            r_gnt_ff <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt_ff <= w_pick_idx;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_vld_sel && i_ready) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_ptr_next;
                    end else if (!w_vld_sel) begin
                        // Requester withdrew before handshake: no credit taken.
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output steering; everything except the response is quiet in IDLE.
    always_comb begin
        o_resp  = i_resp;
        o_cmd   = '0;
        o_valid = 1'b0;
        o_gnt   = '0;
        o_ready = '0;
        o_busy  = 1'b0;
        if (r_state == GRANT) begin
            o_cmd   = w_cmd_sel;
            o_valid = w_vld_sel;
            o_gnt   = w_onehot;
            o_ready = w_onehot & {NREQ{i_ready}};
            o_busy  = 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter with NREQ=4, DW=32, AW=8.
module tb_apb_cmd_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int CW   = 1 + DW/8 + DW + AW;
    localparam int RW   = 1 + DW;

    logic                 pclk;
    logic                 presetn;
    logic [NREQ*CW-1:0]   i_cmd;
    logic [NREQ-1:0]      i_valid;
    logic [NREQ-1:0]      o_ready;
    logic [RW-1:0]        o_resp;
    logic [CW-1:0]        o_cmd;
    logic                 o_valid;
    logic [RW-1:0]        i_resp;
    logic                 i_ready;
    logic [NREQ-1:0]      o_gnt;
    logic                 o_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] cmds [NREQ];

    apb_cmd_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .i_cmd   (i_cmd),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_resp  (o_resp),
        .o_cmd   (o_cmd),
        .o_valid (o_valid),
        .i_resp  (i_resp),
        .i_ready (i_ready),
        .o_gnt   (o_gnt),
        .o_busy  (o_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        presetn = 1'b0;
        i_valid = '0;
        i_ready = 1'b0;
        i_resp  = '0;
        for (int k = 0; k < NREQ; k++)
            cmds[k] = {1'b0, 4'h3, 32'hA000_0000 + 32'(k), 8'(8'h20 + k)};
        cmds[2] = {1'b1, 4'hF, 32'h1234_5678, 8'h10};
        for (int k = 0; k < NREQ; k++)
            i_cmd[k*CW +: CW] = cmds[k];

        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        check("rst_gnt",   o_gnt,   0);
        check("rst_busy",  o_busy,  0);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_cmd",   o_cmd,   0);
        presetn = 1'b1;

        // All valid continuously: 0,1,2,3,0 with an IDLE cycle between
        i_valid = 4'b1111;
        i_ready = 1'b1;
        #1;
        check("idle_cmd_zero", o_cmd, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_gnt",   o_gnt,   4'b0001 << order[i]);
            check("rr_ready", o_ready, 4'b0001 << order[i]);
            check("rr_cmd",   o_cmd,   cmds[order[i]]);
            tick();
            check("rr_idle_gnt",  o_gnt,  0);
            check("rr_idle_busy", o_busy, 0);
        end

        // Single request on requester 2 (pointer now 1)
        i_valid = 4'b0100;
        #1;
        check("single_pre_gnt", o_gnt, 0);
        tick();
        check("single_gnt",   o_gnt,   4'b0100);
        check("single_cmd",   o_cmd,   {1'b1, 4'hF, 32'h1234_5678, 8'h10});
        check("single_valid", o_valid, 1);
        check("single_ready", o_ready, 4'b0100);
        tick();
        check("single_idle_gnt",   o_gnt,   0);
        check("single_idle_ready", o_ready, 0);

        // Pointer 3, valid 0011: wrap to 0, then 1
        i_valid = 4'b0011;
        tick();
        check("wrap_gnt0", o_gnt, 4'b0001);
        tick();
        i_valid = 4'b0010;
        tick();
        check("wrap_gnt1", o_gnt, 4'b0010);
        tick();
        i_valid = 4'b0000;

        // Downstream stall: grant held, other valids ignored
        i_ready = 1'b0;
        i_valid = 4'b0100;
        tick();
        check("stall_gnt0", o_gnt, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            i_valid = 4'b1100;
            tick();
            check("stall_gnt",   o_gnt,   4'b0100);
            check("stall_cmd",   o_cmd,   cmds[2]);
            check("stall_ready", o_ready, 0);
            check("stall_valid", o_valid, 1);
        end
        i_ready = 1'b1;
        #1;
        check("stall_release_ready", o_ready, 4'b0100);
        tick();
        check("stall_done_gnt", o_gnt, 0);
        i_valid = 4'b1000;
        tick();
        check("pre_rst_gnt", o_gnt, 4'b1000);

        // Reset mid-grant
        presetn = 1'b0;
        #1;
        check("midrst_gnt",   o_gnt,   0);
        check("midrst_busy",  o_busy,  0);
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 0);
        check("midrst_cmd",   o_cmd,   0);
        #2;
        presetn = 1'b1;
        i_valid = 4'b1000;
        i_ready = 1'b1;
        tick();
        check("postrst_gnt", o_gnt, 4'b1000);
        tick();
        check("postrst_idle", o_busy, 0);
        // Pointer should be 0 after serving requester 3
        i_ready = 1'b0;
        i_valid = 4'b1001;
        tick();
        check("ptr_wrap_gnt", o_gnt, 4'b0001);

        // Granted requester withdraws: back to IDLE, pointer unchanged
        i_valid = 4'b1000;
        #1;
        check("withdraw_valid", o_valid, 0);
        tick();
        check("withdraw_idle", o_gnt, 0);
        i_valid = 4'b1001;
        tick();
        check("withdraw_ptr_gnt", o_gnt, 4'b0001);

        // Response pass-through with error and read data
        i_resp  = {1'b1, 32'hDEAD_BEEF};
        i_ready = 1'b1;
        #1;
        check("resp_value", o_resp,  33'h1_DEAD_BEEF);
        check("resp_ready", o_ready, 4'b0001);
        check("resp_valid", o_valid, 1);
        tick();
        check("resp_idle", o_gnt, 0);
        i_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
